pixel_streamer: RTL and testbench
=================================

PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320, pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 240, lines per frame.
REQ-003 SHALL have parameter RAM_LATENCY, default 2, frame-RAM read latency in cycles (1..4).
REQ-004 SHALL have port clk_in, input, 1, the single clock.
REQ-005 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_in, input, 1, single-cycle request to stream one frame.
REQ-007 SHALL have port addr_out, output, $clog2(H_ACTIVE*V_ACTIVE), frame-RAM read address.
REQ-008 SHALL have port ram_data_in, input, 7, frame-RAM read data.
REQ-009 SHALL have port data_valid_out, output, 1, pixel beat valid.
REQ-010 SHALL have port pixel_data_out, output, 7, pixel value.
REQ-011 SHALL have port hcount_out, output, 11, column of current beat.
REQ-012 SHALL have port vcount_out, output, 10, row of current beat.
REQ-013 SHALL have port busy_out, output, 1, high from accepted start until the last beat leaves.
REQ-014 SHALL have port done_out, output, 1, one-cycle pulse coincident with the last beat of the frame.

Function
REQ-015 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-016 In IDLE, start_in=1 SHALL move to READ with address 0; start_in in READ/DRAIN SHALL be ignored.
REQ-017 In READ, one address per cycle in raster order (addr = v*H_ACTIVE+h), h wrapping at H_ACTIVE-1 and v incrementing.
REQ-018 After issuing address H_ACTIVE*V_ACTIVE-1, SHALL enter DRAIN and hold addr_out.
REQ-019 The beat for address A SHALL appear on data_valid_out/pixel_data_out/hcount_out/vcount_out exactly RAM_LATENCY+1 cycles after addr_out=A.
REQ-020 hcount_out/vcount_out SHALL be delayed through a RAM_LATENCY+1 stage pipeline alongside valid, never recomputed at the output.
REQ-021 DRAIN SHALL last until the pipeline is empty; on the last beat done_out=1, then IDLE next cycle.
REQ-022 busy_out SHALL deassert the cycle after done_out.
REQ-023 start_in coincident with done_out SHALL be ignored; a new start is accepted only in IDLE.
REQ-024 data_valid_out SHALL never assert outside a frame; hcount_out/vcount_out hold their last values when not valid.

Reset
REQ-025 rst_in low SHALL asynchronously force IDLE, clear the pipeline, and set all outputs to 0.
REQ-026 Reset mid-frame SHALL abort; no further beats and no done_out after release.

Configuration
REQ-027 Macro LINE_GAP_EN, when defined, SHALL add parameter H_GAP (default 4) and stall address issue for H_GAP cycles after each line's last address, so data_valid_out is low H_GAP cycles between lines.
REQ-028 Without LINE_GAP_EN, beats SHALL be back-to-back for the whole frame (H_ACTIVE*V_ACTIVE consecutive valid cycles).

Structure
REQ-029 A shared package SHALL hold the FSM state enum and pixel/hcount/vcount width constants (7, 11, 10), also used by the downstream filter chain.
REQ-030 A sub-module delay_pipe (parameterised depth and width) SHALL implement the valid/hcount/vcount pipeline.

Verification
REQ-031 H_ACTIVE=4, V_ACTIVE=3, RAM_LATENCY=2, RAM model returns addr[6:0]: start -> 12 consecutive beats, pixel=0..11, (h,v)=(0,0)..(3,2), first beat 3 cycles after addr 0.
REQ-032 Same config: done_out pulses exactly with pixel=11 and busy_out falls the next cycle.
REQ-033 start_in pulsed during READ and again on done_out cycle -> exactly one frame of 12 beats.
REQ-034 rst_in low after beat 5 -> all outputs 0 immediately; no beats or done_out within 20 cycles after release.
REQ-035 LINE_GAP_EN, H_GAP=4 -> 4 invalid cycles between h=3 and next h=0; total frame length 12+2*4 beats-window.
REQ-036 RAM_LATENCY=4 -> pixel/hcount alignment identical to REQ-031, first beat 5 cycles after addr 0.

Source files
------------

// File: rtl/pixel_streamer_pkg.sv
// Shared definitions for the pixel streamer and the downstream filter chain:
// FSM state encoding and the pixel / column / row bus widths.
package pixel_streamer_pkg;

    localparam int PIX_W  = 7;
    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_streamer_delay_pipe.sv
// Fixed-depth register delay line. Clears every stage on reset so that an
// aborted frame leaves nothing in flight.
module delay_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the input through DEPTH registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= {WIDTH{1'b0}};
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/pixel_streamer.sv
// Frame-RAM reader: on start, walks the frame in raster order one address per
// cycle and presents each pixel with its column/row RAM_LATENCY+1 cycles after
// the address was issued. Column/row/valid travel through a delay line so they
// line up with the RAM data without being recomputed.
// Optional build macro LINE_GAP_EN adds parameter H_GAP: H_GAP idle cycles
// are inserted after the last address of each line.
module pixel_streamer
    import pixel_streamer_pkg::*;
#(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int RAM_LATENCY = 2
`ifdef LINE_GAP_EN
    ,
    parameter int H_GAP       = 4
`endif
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  start_in,
    output logic [$clog2(H_ACTIVE*V_ACTIVE)-1:0]  addr_out,
    input  logic [PIX_W-1:0]                      ram_data_in,
    output logic                                  data_valid_out,
    output logic [PIX_W-1:0]                      pixel_data_out,
    output logic [HCNT_W-1:0]                     hcount_out,
    output logic [VCNT_W-1:0]                     vcount_out,
    output logic                                  busy_out,
    output logic                                  done_out
);

    localparam int AW     = $clog2(H_ACTIVE*V_ACTIVE);
    localparam int PIPE_W = 2 + HCNT_W + VCNT_W;
    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_ACTIVE - 1);
    localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_ACTIVE - 1);
`ifdef LINE_GAP_EN
    localparam logic [15:0] GAP_LOAD = 16'(H_GAP);
`else
    localparam logic [15:0] GAP_LOAD = 16'd0;
`endif

    state_t              r_state;
    logic [AW-1:0]       r_addr;
    logic [HCNT_W-1:0]   r_h;
    logic [VCNT_W-1:0]   r_v;
    logic                r_issue;
    logic [15:0]         r_gap_cnt;
    logic                r_busy;

    logic                r_valid;
    logic                r_done;
    logic [PIX_W-1:0]    r_pix;
    logic [HCNT_W-1:0]   r_hcnt;
    logic [VCNT_W-1:0]   r_vcnt;

    logic                w_line_end;
    logic                w_frame_end;
    logic [AW-1:0]       w_next_addr;
    logic [HCNT_W-1:0]   w_next_h;
    logic [VCNT_W-1:0]   w_next_v;
    logic [PIPE_W-1:0]   w_pipe_in;
    logic [PIPE_W-1:0]   w_pipe_out;
    logic                w_p_valid;
    logic                w_p_last;
    logic [HCNT_W-1:0]   w_p_h;
    logic [VCNT_W-1:0]   w_p_v;

    assign w_line_end  = (r_h == H_LAST);
    assign w_frame_end = w_line_end && (r_v == V_LAST);

    // Next raster position after the currently issued address.
    always_comb begin
        w_next_addr = r_addr + AW'(1);
        if (w_line_end) begin
            w_next_h = {HCNT_W{1'b0}};
            w_next_v = r_v + VCNT_W'(1);
        end else begin
            w_next_h = r_h + HCNT_W'(1);
            w_next_v = r_v;
        end
    end

    // Control FSM: address issue, optional line gap, drain and busy flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= ST_IDLE;
            r_addr    <= {AW{1'b0}};
            r_h       <= {HCNT_W{1'b0}};
            r_v       <= {VCNT_W{1'b0}};
            r_issue   <= 1'b0;
            r_gap_cnt <= 16'd0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_gap_cnt <= 16'd0;
                    if (start_in) begin
                        r_state <= ST_READ;
                        r_addr  <= {AW{1'b0}};
                        r_h     <= {HCNT_W{1'b0}};
                        r_v     <= {VCNT_W{1'b0}};
                        r_issue <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_issue <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (r_gap_cnt != 16'd0) begin
                        // Stalled between lines; resume on the last gap cycle.
                        r_gap_cnt <= r_gap_cnt - 16'd1;
                        if (r_gap_cnt == 16'd1) begin
                            r_addr  <= w_next_addr;
                            r_h     <= w_next_h;
                            r_v     <= w_next_v;
                            r_issue <= 1'b1;
                        end else begin
                            r_issue <= 1'b0;
                        end
                    end else if (w_frame_end) begin
                        r_state <= ST_DRAIN;
                        r_issue <= 1'b0;
                    end else if (w_line_end && (GAP_LOAD != 16'd0)) begin
                        r_gap_cnt <= GAP_LOAD;
                        r_issue   <= 1'b0;
                    end else begin
                        r_addr  <= w_next_addr;
                        r_h     <= w_next_h;
                        r_v     <= w_next_v;
                        r_issue <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_issue <= 1'b0;
                    // Last beat is on the outputs this cycle; frame ends here.
                    if (r_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_issue <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_pipe_in = {r_issue, r_issue & w_frame_end, r_h, r_v};

    delay_pipe #(
        .DEPTH (RAM_LATENCY),
        .WIDTH (PIPE_W)
    ) u_delay_pipe (
        .i_clk   (clk_in),
        .i_rst_n (rst_in),
        .i_data  (w_pipe_in),
        .o_data  (w_pipe_out)
    );

    assign {w_p_valid, w_p_last, w_p_h, w_p_v} = w_pipe_out;

    // Final pipeline stage: capture RAM data alongside the delayed position.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_pix   <= {PIX_W{1'b0}};
            r_hcnt  <= {HCNT_W{1'b0}};
            r_vcnt  <= {VCNT_W{1'b0}};
        end else begin
            r_valid <= w_p_valid;
            r_done  <= w_p_valid & w_p_last;
            if (w_p_valid) begin
                r_pix  <= ram_data_in;
                r_hcnt <= w_p_h;
                r_vcnt <= w_p_v;
            end
        end
    end

    assign addr_out       = r_addr;
    assign data_valid_out = r_valid;
    assign pixel_data_out = r_pix;
    assign hcount_out     = r_hcnt;
    assign vcount_out     = r_vcnt;
    assign busy_out       = r_busy;
    assign done_out       = r_done;

endmodule

// File: tb/tb_pixel_streamer.sv
// Directed bench for pixel_streamer: a 4x3 frame with RAM latency 2 and 4
// (the RAM model returns the low address bits as pixel data), start filtering,
// and mid-frame reset. Honours LINE_GAP_EN by expecting 4-cycle line gaps.
module tb_pixel_streamer;
    import pixel_streamer_pkg::*;

    localparam int H = 4;
    localparam int V = 3;
`ifdef LINE_GAP_EN
    localparam int GAP = 4;
`else
    localparam int GAP = 0;
`endif
    localparam int NLAST2 = 2 + 1 + (H*V - 1) + (V - 1)*GAP;
    localparam int NLAST4 = 4 + 1 + (H*V - 1) + (V - 1)*GAP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start2, start4;
    logic [3:0] addr2, addr4;
    logic [6:0] ram2, ram4, pix2, pix4;
    logic v2, v4, busy2, busy4, done2, done4;
    logic [10:0] h2, h4;
    logic [9:0] vc2, vc4;
    logic [6:0] rq2 [1:2];
    logic [6:0] rq4 [1:4];

    int vectors = 0;
    int errs = 0;

    // Frame-RAM models with read latency 2 and 4.
    always @(posedge clk) begin
        rq2[1] <= {3'b000, addr2};
        rq2[2] <= rq2[1];
        rq4[1] <= {3'b000, addr4};
        for (int i = 2; i <= 4; i++) rq4[i] <= rq4[i-1];
    end
    assign ram2 = rq2[2];
    assign ram4 = rq4[4];

    pixel_streamer #(.H_ACTIVE(H), .V_ACTIVE(V), .RAM_LATENCY(2)
`ifdef LINE_GAP_EN
        , .H_GAP(GAP)
`endif
    ) dut (
        .clk_in(clk), .rst_in(rst_n), .start_in(start2), .addr_out(addr2),
        .ram_data_in(ram2), .data_valid_out(v2), .pixel_data_out(pix2),
        .hcount_out(h2), .vcount_out(vc2), .busy_out(busy2), .done_out(done2)
    );

    pixel_streamer #(.H_ACTIVE(H), .V_ACTIVE(V), .RAM_LATENCY(4)
`ifdef LINE_GAP_EN
        , .H_GAP(GAP)
`endif
    ) dut4 (
        .clk_in(clk), .rst_in(rst_n), .start_in(start4), .addr_out(addr4),
        .ram_data_in(ram4), .data_valid_out(v4), .pixel_data_out(pix4),
        .hcount_out(h4), .vcount_out(vc4), .busy_out(busy4), .done_out(done4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Beat index expected n cycles after address 0 was issued, or -1.
    function automatic int beat_at(input int n, input int lat);
        for (int k = 0; k < H*V; k++) begin
            if (n == lat + 1 + k + (k / H) * GAP) return k;
        end
        return -1;
    endfunction

    initial begin
        int k2, k4, beats, dones;
        bit found;

        rst_n = 1'b0; start2 = 1'b0; start4 = 1'b0;
        repeat (3) tick;
        check("rst_valid", v2, 1'b0);
        check("rst_pix", pix2, 7'd0);
        check("rst_h", h2, 11'd0);
        check("rst_v", vc2, 10'd0);
        check("rst_busy", busy2, 1'b0);
        check("rst_done", done2, 1'b0);
        check("rst_addr", addr2, 4'd0);
        rst_n = 1'b1;
        tick;

        // Frame 1: both latencies, cycle-by-cycle.
        start2 = 1'b1; start4 = 1'b1;
        tick;
        start2 = 1'b0; start4 = 1'b0;
        check("f1_addr0", addr2, 4'd0);
        check("f1_addr0_l4", addr4, 4'd0);
        for (int n = 0; n <= NLAST4 + 3; n++) begin
            k2 = beat_at(n, 2);
            k4 = beat_at(n, 4);
            check("l2_valid", v2, k2 >= 0);
            check("l2_done", done2, k2 == H*V - 1);
            check("l2_busy", busy2, n <= NLAST2);
            if (k2 >= 0) begin
                check("l2_pix", pix2, k2);
                check("l2_h", h2, k2 % H);
                check("l2_v", vc2, k2 / H);
            end
            check("l4_valid", v4, k4 >= 0);
            check("l4_done", done4, k4 == H*V - 1);
            check("l4_busy", busy4, n <= NLAST4);
            if (k4 >= 0) begin
                check("l4_pix", pix4, k4);
                check("l4_h", h4, k4 % H);
                check("l4_v", vc4, k4 / H);
            end
            tick;
        end
        check("hold_h", h2, 11'd3);
        check("hold_v", vc2, 10'd2);
        check("hold_pix", pix2, 7'd11);
        check("hold_addr", addr2, 4'd11);

        // Frame 2: extra starts during READ and on the done cycle are ignored.
        start2 = 1'b1;
        tick;
        beats = 0; dones = 0;
        for (int n = 0; n <= NLAST2 + 25; n++) begin
            if (v2 === 1'b1) beats++;
            if (done2 === 1'b1) dones++;
            start2 = (n == 5) || (n == NLAST2);
            tick;
        end
        start2 = 1'b0;
        check("f2_beats", beats, H*V);
        check("f2_dones", dones, 1);
        check("f2_busy", busy2, 1'b0);

        // Frame 3: reset right after beat 5.
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            if (v2 === 1'b1 && pix2 === 7'd5) found = 1'b1;
            else tick;
        end
        check("beat5_seen", found, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_valid", v2, 1'b0);
        check("abort_pix", pix2, 7'd0);
        check("abort_h", h2, 11'd0);
        check("abort_v", vc2, 10'd0);
        check("abort_busy", busy2, 1'b0);
        check("abort_done", done2, 1'b0);
        check("abort_addr", addr2, 4'd0);
        #2;
        rst_n = 1'b1;
        beats = 0; dones = 0;
        for (int n = 0; n < 20; n++) begin
            tick;
            if (v2 !== 1'b0) beats++;
            if (done2 !== 1'b0) dones++;
        end
        check("post_rst_beats", beats, 0);
        check("post_rst_dones", dones, 0);
        check("post_rst_busy", busy2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
